// File: rtl/mst_chn_sched_pkg.sv
// Shared types and constants for the master-bus write-channel scheduler.
package mst_chn_sched_pkg;

  localparam int unsigned NCH           = 4;
  localparam int unsigned PW            = 2;
  localparam int unsigned CW_DEF        = 11;
  localparam int unsigned BURST_MAX_DEF = 1024;

  localparam logic [NCH-1:0] CH0_MASK = NCH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_OFFER,
    ST_XFER,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] chn;
    logic          last;
  } gnt_t;

endpackage

// File: rtl/mst_chn_sched_if.sv
// Scheduler <-> FIFO-status / bus-FSM signal bundle.
interface mst_chn_sched_if
  import mst_chn_sched_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
);
  logic           mltcn;
  logic [NCH-1:0] chn_nempt;
  logic [NCH-1:0] chn_rdy;
  logic           fsm_acc;
  logic           xfer_beat;
  logic           xfer_abort;
  logic           gnt_vld;
  logic [PW-1:0]  gnt_chn;
  logic           gnt_last;
  logic           busy;
  logic [CW-1:0]  beat_cnt;

  modport slave (
    input  mltcn, chn_nempt, chn_rdy, fsm_acc, xfer_beat, xfer_abort,
    output gnt_vld, gnt_chn, gnt_last, busy, beat_cnt
  );

  modport master (
    output mltcn, chn_nempt, chn_rdy, fsm_acc, xfer_beat, xfer_abort,
    input  gnt_vld, gnt_chn, gnt_last, busy, beat_cnt
  );
endinterface

// File: rtl/mst_chn_sched_rr_pick.sv
// Combinational 4-way rotating-priority picker; search starts at i_ptr+1.
module mst_rr_pick
  import mst_chn_sched_pkg::*;
(
  input  logic [NCH-1:0] i_elig,
  input  logic [PW-1:0]  i_ptr,
  output logic           o_hit,
  output logic [PW-1:0]  o_idx
);

  logic [PW-1:0] w_cand;

  // Walk from farthest to nearest so the nearest eligible channel wins.
  always_comb begin
    o_hit  = |i_elig;
    o_idx  = '0;
    w_cand = '0;
    for (int k = int'(NCH); k >= 1; k--) begin
      w_cand = i_ptr + PW'(k);
      if (i_elig[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/mst_chn_sched.sv
// Round-robin write-channel scheduler with per-grant burst cap.
module mst_chn_sched
  import mst_chn_sched_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF,
  parameter int unsigned CW        = CW_DEF
)(
  input  logic           clk,
  input  logic           rst,
  mst_chn_sched_if.slave bus
);

  state_t         r_state, w_state_nxt;
  gnt_t           r_gnt, w_gnt_nxt;
  logic [PW-1:0]  r_ptr, w_ptr_nxt;
  logic [CW-1:0]  r_beat_cnt, w_cnt_nxt;
  logic           r_busy;
  logic [NCH-1:0] w_raw, w_elig;
  logic           w_hit;
  logic [PW-1:0]  w_idx;
  logic           w_end;

  assign w_raw  = bus.chn_nempt & bus.chn_rdy;
  assign w_elig = bus.mltcn ? w_raw : (w_raw & CH0_MASK);

  mst_rr_pick u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_ptr      <= PW'(NCH - 1);
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  // Offer/drop checks use unmasked eligibility so a mode change never cuts a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_beat_cnt;
    w_end       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_elig != '0) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (!w_hit) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt    = ST_OFFER;
          w_gnt_nxt.chn  = w_idx;
          w_gnt_nxt.vld  = 1'b1;
          w_gnt_nxt.last = (BURST_MAX == 1);
          w_cnt_nxt      = '0;
        end
      end
      ST_OFFER: begin
        if (!w_raw[r_gnt.chn]) begin
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt.vld  = 1'b0;
          w_gnt_nxt.last = 1'b0;
        end else if (bus.fsm_acc) begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (bus.xfer_beat && (r_beat_cnt < CW'(BURST_MAX)))
          w_cnt_nxt = r_beat_cnt + CW'(1);
        w_end = (bus.xfer_beat && r_gnt.last) || bus.xfer_abort ||
                !bus.chn_nempt[r_gnt.chn];
        if (w_end) begin
          w_state_nxt    = ST_DONE;
          w_gnt_nxt.vld  = 1'b0;
          w_gnt_nxt.last = 1'b0;
        end else begin
          w_gnt_nxt.last = (w_cnt_nxt == CW'(BURST_MAX - 1));
        end
      end
      ST_DONE: begin
        if (r_beat_cnt != '0) w_ptr_nxt = r_gnt.chn;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.gnt_vld  = r_gnt.vld;
  assign bus.gnt_chn  = r_gnt.chn;
  assign bus.gnt_last = r_gnt.last;
  assign bus.busy     = r_busy;
  assign bus.beat_cnt = r_beat_cnt;

endmodule

// File: doc/mst_chn_sched.md
Name: mst_chn_sched

Overview:
- Round-robin write-channel scheduler for the master FIFO bus in multi-channel mode.
- Picks which internal channel FIFO (ch0..ch3) the bus FSM drains next toward the FT601, and caps each grant at a burst limit so one channel cannot starve the others.
- Sits between the internal FIFO controller status (non-empty flags), the per-channel device-ready status, and the bus FSM that drives WR_N/DATA.
- In 245 mode only channel 0 is scheduled.

Parameters:
- NCH, 4, number of channels (fixed at 4; logic is sized for it).
- BURST_MAX, 1024, maximum 32-bit words per grant; legal range 1..2^CW-1.
- CW, 11, width of the beat counter.

Ports:
- clk  in  1  bus clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mltcn  in  1  1 = multi-channel mode, 0 = 245 mode (channel 0 only); sampled every cycle.
- chn_nempt  in  4  per-channel internal FIFO non-empty.
- chn_rdy  in  4  per-channel device-side ready (FT601 has room on that channel).
- fsm_acc  in  1  bus FSM accepts the offered grant; meaningful only while gnt_vld=1.
- xfer_beat  in  1  one word moved on the granted channel this cycle.
- xfer_abort  in  1  bus FSM ended the burst early (TXE_N deasserted).
- gnt_vld  out  1  grant offered or active.
- gnt_chn  out  2  granted channel index.
- gnt_last  out  1  the next beat is the last permitted in this grant.
- busy  out  1  high in every state except IDLE.
- beat_cnt  out  CW  beats completed in the current grant.

Behaviour:
- Reset values: gnt_vld=0, gnt_chn=0, gnt_last=0, busy=0, beat_cnt=0, state=IDLE, last-served pointer=3 (so the first pick starts at ch0).
- Eligibility: elig[i] = chn_nempt[i] & chn_rdy[i]. When mltcn=0, elig is masked to bit 0.
- IDLE -> ARB when elig != 0.
- ARB (1 cycle):
  - Rotating priority starting at pointer+1 mod 4; the first eligible channel is registered into gnt_chn.
  - If elig has dropped to 0 this cycle, return to IDLE.
  - In 245 mode gnt_chn is always 0.
- OFFER:
  - gnt_vld=1, beat_cnt=0.
  - fsm_acc=1 -> XFER.
  - If elig[gnt_chn] falls before acceptance, drop gnt_vld next cycle and go to IDLE; the pointer is not updated.
- XFER:
  - gnt_vld stays 1. Each xfer_beat increments beat_cnt.
  - gnt_last is registered, high when beat_cnt == BURST_MAX-1.
  - End conditions, checked on the same edge: xfer_beat with gnt_last=1, xfer_abort=1, or chn_nempt[gnt_chn]=0 → DONE.
  - A beat and an abort in the same cycle: the beat is counted, then the grant ends.
  - beat_cnt never exceeds BURST_MAX. Beats arriving after gnt_last has been consumed are ignored; a bench assertion flags them.
- DONE (1 cycle):
  - gnt_vld=0, gnt_last=0. The pointer is set to gnt_chn only if at least one beat occurred; otherwise the pointer is unchanged, so an aborted empty grant keeps the same priority.
  - Then -> IDLE. There is a minimum 1-cycle gap between grants.
- A change of mltcn mid-grant does not cut the grant; it takes effect at the next ARB.
- rst asserted in any state: on the next edge all outputs and the pointer return to their reset values. No grant survives reset.
- Grant latency: elig rising in IDLE gives gnt_vld high 2 cycles later (IDLE -> ARB -> OFFER).

Decomposition:
- Shared package holds: the state encoding (IDLE, ARB, OFFER, XFER, DONE), NCH, and the default BURST_MAX.
- One natural sub-module: mst_rr_pick, a combinational 4-way rotate-priority picker. Inputs: elig[3:0] and pointer[1:0]. Outputs: hit and idx[1:0].

Test Plan:
- Reset, then elig=4'b1111, mltcn=1, each grant accepted and 3 beats then abort -> grants ch0, ch1, ch2, ch3, ch0 in order; gnt_vld rises 2 cycles after elig.
- BURST_MAX=4, ch2 alone eligible, continuous beats -> gnt_last high after beat 3; beat_cnt=4; DONE; ch2 re-granted after the IDLE gap.
- mltcn=0, elig=4'b1110 -> no grant. Then set chn_nempt[0]=1 and chn_rdy[0]=1 -> gnt_chn=0, always.
- During OFFER on ch1, drop chn_rdy[1] -> gnt_vld=0 next cycle, pointer unchanged, and with ch1 restored the next pick is ch1 again.
- xfer_beat and xfer_abort in the same cycle with beat_cnt=5 -> beat_cnt=6, DONE, pointer=gnt_chn.
- Assert rst while in XFER with beat_cnt=7 -> next cycle all outputs 0 and the first subsequent grant is ch0.
